// File: rtl/servo_pwm_multi.sv
// -----------------------------------------------------------------------------
// servo_pwm_multi
//
// Multi-channel hobby-servo PWM driver. Each channel keeps a clamped target
// angle and a current angle. Once per frame the current angle moves toward the
// target, limited to SLEW_STEP degrees, and is converted to a pulse width of
// MIN_PULSE + STEP * angle clocks. That width then stays fixed for the whole
// following frame.
//
// Ports
//   clk          sole clock
//   rst_n        asynchronous active-low reset
//   wr_valid     angle write strobe (always accepted)
//   wr_ch        channel index of the write
//   wr_angle     commanded angle in degrees (clamped to MAX_ANGLE)
//   en           per-channel output enable, level-sensitive
//   pwm_out      registered servo pulses, lag the frame counter by one cycle
//   frame_start  high during the cycle where the frame counter equals 0
//   settled      registered, bit i set when current angle i equals target i
//   wr_err       registered one-cycle pulse for a write to a nonexistent channel
// -----------------------------------------------------------------------------
module servo_pwm_multi #(
  parameter int CHANNELS      = 4,
  parameter int ANGLE_W       = 8,
  parameter int PERIOD_CYCLES = 2_000_000,
  parameter int MIN_PULSE     = 100_000,
  parameter int STEP          = 555,
  parameter int MAX_ANGLE     = 180,
  parameter int SLEW_STEP     = 0,
  parameter int RESET_ANGLE   = 90,
  localparam int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int CNT_W        = $clog2(PERIOD_CYCLES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_valid,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [ANGLE_W-1:0]  wr_angle,
  input  logic [CHANNELS-1:0] en,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                frame_start,
  output logic [CHANNELS-1:0] settled,
  output logic                wr_err
);

  // A MAX_ANGLE that does not fit in ANGLE_W can never be exceeded by a
  // command, so the clamp is only built when it can actually trigger.
  localparam bit CLAMP_EN = ((MAX_ANGLE >> ANGLE_W) == 0);
  localparam logic [ANGLE_W-1:0] MAX_A = ANGLE_W'(MAX_ANGLE);

  // A slew limit wider than the angle range never limits anything.
  localparam bit SLEW_EN = (SLEW_STEP != 0) && ((SLEW_STEP >> ANGLE_W) == 0);
  localparam logic [ANGLE_W-1:0] SLEW_A = ANGLE_W'(SLEW_STEP);

  localparam logic [ANGLE_W-1:0] RESET_A     = ANGLE_W'(RESET_ANGLE);
  localparam logic [CNT_W-1:0]   LAST_CNT    = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   RESET_WIDTH = CNT_W'(MIN_PULSE + STEP * RESET_ANGLE);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ANGLE_W-1:0]  tgt_q   [CHANNELS];
  logic [ANGLE_W-1:0]  tgt_d   [CHANNELS];
  logic [ANGLE_W-1:0]  cur_q   [CHANNELS];
  logic [ANGLE_W-1:0]  cur_d   [CHANNELS];
  logic [CNT_W-1:0]    width_q [CHANNELS];
  logic [CNT_W-1:0]    width_d [CHANNELS];
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic [CHANNELS-1:0] settled_q, settled_d;
  logic                frame_start_q, frame_start_d;
  logic                wr_err_q, wr_err_d;

  logic                boundary;
  logic                wr_ch_ok;
  logic [ANGLE_W-1:0]  wr_angle_clamped;

  // One slew step: jump when within the limit (or unlimited), otherwise move
  // by exactly the limit. Operands stay inside [0, MAX_ANGLE], so neither the
  // subtraction nor the addition can wrap.
  function automatic logic [ANGLE_W-1:0] slew_next(input logic [ANGLE_W-1:0] cur,
                                                   input logic [ANGLE_W-1:0] tgt);
    logic [ANGLE_W-1:0] res;
    res = tgt;
    if (SLEW_EN) begin
      if (tgt > cur) begin
        if ((tgt - cur) > SLEW_A) res = cur + SLEW_A;
      end else begin
        if ((cur - tgt) > SLEW_A) res = cur - SLEW_A;
      end
    end
    return res;
  endfunction

  // Legal parameters guarantee the result fits in CNT_W bits.
  function automatic logic [CNT_W-1:0] pulse_width(input logic [ANGLE_W-1:0] ang);
    return CNT_W'(MIN_PULSE) + CNT_W'(STEP) * CNT_W'(ang);
  endfunction

  assign boundary = (cnt_q == LAST_CNT);

  // Compare with one extra bit so a CHANNELS equal to 2**CH_W still works.
  assign wr_ch_ok = ({1'b0, wr_ch} < (CH_W + 1)'(CHANNELS));

  always_comb begin
    wr_angle_clamped = wr_angle;
    if (CLAMP_EN && (wr_angle > MAX_A)) wr_angle_clamped = MAX_A;
  end

  always_comb begin
    cnt_d         = boundary ? '0 : cnt_q + CNT_W'(1);
    frame_start_d = (cnt_d == '0);
    wr_err_d      = wr_valid && !wr_ch_ok;
    pwm_d         = '0;
    settled_d     = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      tgt_d[i]   = tgt_q[i];
      cur_d[i]   = cur_q[i];
      width_d[i] = width_q[i];

      // The slew sees the pre-edge target; a write on the same edge only
      // lands in the target register and takes effect at the next boundary.
      if (boundary) begin
        cur_d[i]   = slew_next(cur_q[i], tgt_q[i]);
        width_d[i] = pulse_width(cur_d[i]);
      end

      if (wr_valid && wr_ch_ok && (wr_ch == CH_W'(i))) tgt_d[i] = wr_angle_clamped;

      pwm_d[i]     = en[i] && (cnt_q < width_q[i]);
      settled_d[i] = (cur_q[i] == tgt_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      pwm_q         <= '0;
      settled_q     <= '1;
      frame_start_q <= 1'b0;
      wr_err_q      <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        tgt_q[i]   <= RESET_A;
        cur_q[i]   <= RESET_A;
        width_q[i] <= RESET_WIDTH;
      end
    end else begin
      cnt_q         <= cnt_d;
      pwm_q         <= pwm_d;
      settled_q     <= settled_d;
      frame_start_q <= frame_start_d;
      wr_err_q      <= wr_err_d;
      for (int i = 0; i < CHANNELS; i++) begin
        tgt_q[i]   <= tgt_d[i];
        cur_q[i]   <= cur_d[i];
        width_q[i] <= width_d[i];
      end
    end
  end

  assign pwm_out     = pwm_q;
  assign settled     = settled_q;
  assign frame_start = frame_start_q;
  assign wr_err      = wr_err_q;

endmodule
